i2s_seq_ctrl: RTL and testbench
===============================

I2S_SEQ_CTRL -- requirements
Module: i2s_seq_ctrl

Interface
REQ-001 SHALL have port clk  in  1  system/serial clock; all state updates on rising edge.
REQ-002 SHALL have port rst_  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cmd_valid  in  1  transfer command offered.
REQ-004 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready both high.
REQ-005 SHALL have port cmd_frames  in  16  frames to transfer; 0 = continuous.
REQ-006 SHALL have port cmd_cfg  in  5  {mode[1:0] (0=MT,1=MR,2=ST,3=SR), stereo, frame_size (1=32b), standard (1=I2S)}.
REQ-007 SHALL have port stop_req  in  1  graceful stop request, level or pulse.
REQ-008 SHALL have port abort  in  1  immediate stop.
REQ-009 SHALL have port frame_start  in  1  one-cycle pulse when the WS generator/tracker leaves IDLE into L.
REQ-010 SHALL have port frame_end  in  1  one-cycle pulse on the last bit of a frame (end of R if stereo, end of L if mono).
REQ-011 SHALL have ports tx_empty, rx_full  in  1 each  FIFO status.
REQ-012 SHALL have port err_clr  in  1  clears err.
REQ-013 SHALL have port op_cfg  out  5  applied configuration to the WS/datapath blocks.
REQ-014 SHALL have port tran_en  out  1  transfer enable to the WS generator.
REQ-015 SHALL have ports busy  out  1 (state != IDLE) and done  out  1 (one-cycle completion pulse).
REQ-016 SHALL have port frames_done  out  16  completed-frame count.
REQ-017 SHALL have port err  out  2  sticky; bit0 TX underrun, bit1 RX overrun.

Function
REQ-018 SHALL implement states IDLE, ARM, RUN, LAST; all outputs registered.
REQ-019 cmd_ready SHALL be 1 only in IDLE with abort low.
- On accept: latch cmd_cfg into op_cfg, latch cmd_frames as target, clear frames_done, go to ARM.
REQ-020 op_cfg SHALL remain constant from accept until the next accept, including through IDLE.
REQ-021 ARM: tran_en=1 when ready, 0 otherwise.
- Ready: mode MT and !tx_empty; mode MR and !rx_full; always ready in ST/SR.
- On frame_start: go to LAST if target==1, else RUN.
REQ-022 RUN: tran_en=1; each frame_end increments frames_done (16-bit, wraps).
- Go to LAST when the incremented value equals target-1 (target != 0).
REQ-023 RUN with target==0: stop_req (or a stop latched earlier in ARM/RUN) moves to LAST on the next cycle; the current frame completes.
REQ-024 LAST: tran_en=0; on frame_end increment frames_done, pulse done next cycle, go to IDLE.
REQ-025 stop_req in IDLE or LAST SHALL be ignored; the latched stop clears on entering IDLE.
REQ-026 stop_req in RUN with finite target SHALL move to LAST early; done still pulses, frames_done reports the actual count.
REQ-027 abort in ARM, RUN or LAST SHALL force IDLE next cycle: tran_en=0, no done, no increment even with coincident frame_end.
REQ-028 err[0] SHALL set on frame_end in RUN when mode MT and tx_empty.
REQ-029 err[1] SHALL set on frame_end in RUN when mode MR and rx_full.
REQ-030 err_clr SHALL clear err; a coincident set wins.
REQ-031 A new frame_end in ARM SHALL NOT count; frame_start outside ARM SHALL be ignored.

Reset
REQ-032 On rst_ low: state IDLE, tran_en 0, op_cfg 0, frames_done 0, err 0, done 0, busy 0, cmd_ready 1 after release, stop latch cleared.
REQ-033 Reset mid-transfer SHALL drop tran_en asynchronously; no done pulse.

Verification
REQ-034 Cmd frames=3, MT, tx_empty=0, frame_start then 3 frame_ends -> tran_en high until 2nd frame_end, one done pulse, frames_done=3, IDLE.
REQ-035 Cmd frames=1 -> LAST immediately after frame_start (tran_en 0), done after first frame_end, frames_done=1.
REQ-036 Cmd frames=0 SR, 5 frame_ends, stop_req, 1 frame_end -> frames_done=6, done pulse, err=0.
REQ-037 MT, tx_empty=1 at 2nd frame_end in RUN -> err=01, sticky; err_clr with coincident underrun -> err stays 01.
REQ-038 abort coincident with frame_end in RUN -> IDLE next cycle, frames_done unchanged, no done; new cmd accepted next cycle.
REQ-039 rst_ low during RUN -> tran_en 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/i2s_seq_ctrl_if.sv
// rtl/i2s_seq_ctrl_if.sv - transfer command handshake bundle for the I2S sequencer
interface i2s_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_frames;
  logic [4:0]  cmd_cfg;

  modport master (output cmd_valid, output cmd_frames, output cmd_cfg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_frames, input cmd_cfg, output cmd_ready);
endinterface

// File: rtl/i2s_seq_ctrl.sv
// rtl/i2s_seq_ctrl.sv - I2S transfer sequencer: arms the WS generator, counts frames, flags FIFO errors
module i2s_seq_ctrl (
  input  logic                 clk,
  input  logic                 rst_,
  i2s_seq_ctrl_if.slave        cmd,
  input  logic                 stop_req,
  input  logic                 abort,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 tx_empty,
  input  logic                 rx_full,
  input  logic                 err_clr,
  output logic [4:0]           op_cfg,
  output logic                 tran_en,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          frames_done,
  output logic [1:0]           err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, LAST} state_t;

  localparam logic [1:0] MODE_MT = 2'd0;
  localparam logic [1:0] MODE_MR = 2'd1;

  state_t      state, state_n;
  logic [15:0] target, target_n;
  logic [15:0] frames_n;
  logic [4:0]  op_cfg_n;
  logic [1:0]  err_n, err_set;
  logic        stop_lat, stop_n;
  logic        tran_en_n, done_n, busy_n;
  logic        rdy_q, rdy_n;
  logic        cmd_ready_w;
  logic        arm_ready;

  // Abort must block acceptance in the very cycle it is asserted, so it gates the registered ready.
  assign cmd_ready_w   = rdy_q & ~abort;
  assign cmd.cmd_ready = cmd_ready_w;

  // Next-state, counters, error flags and registered output values.
  always_comb begin
    state_n   = state;
    target_n  = target;
    frames_n  = frames_done;
    op_cfg_n  = op_cfg;
    stop_n    = stop_lat;
    done_n    = 1'b0;
    tran_en_n = 1'b0;
    arm_ready = 1'b0;

    err_set = 2'b00;
    if (state == RUN && frame_end) begin
      err_set[0] = (op_cfg[4:3] == MODE_MT) && tx_empty;
      err_set[1] = (op_cfg[4:3] == MODE_MR) && rx_full;
    end
    err_n = (err & ~{2{err_clr}}) | err_set;

    case (state)
      IDLE: begin
        if (cmd.cmd_valid && cmd_ready_w) begin
          op_cfg_n = cmd.cmd_cfg;
          target_n = cmd.cmd_frames;
          frames_n = 16'd0;
          state_n  = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          if (stop_req) stop_n = 1'b1;
          if (frame_start) state_n = (target == 16'd1) ? LAST : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          if (stop_req) stop_n = 1'b1;
          if (frame_end) begin
            frames_n = frames_done + 16'd1;
            if (target != 16'd0 && frames_n == target - 16'd1) state_n = LAST;
          end
          if (stop_req || stop_lat) state_n = LAST;
        end
      end
      LAST: begin
        if (abort) begin
          state_n = IDLE;
        end else if (frame_end) begin
          frames_n = frames_done + 16'd1;
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == IDLE) stop_n = 1'b0;

    // Readiness uses the configuration in force next cycle so a fresh command is honoured at once.
    case (op_cfg_n[4:3])
      MODE_MT: arm_ready = ~tx_empty;
      MODE_MR: arm_ready = ~rx_full;
      default: arm_ready = 1'b1;
    endcase

    case (state_n)
      ARM:     tran_en_n = arm_ready;
      RUN:     tran_en_n = 1'b1;
      default: tran_en_n = 1'b0;
    endcase

    busy_n = (state_n != IDLE);
    rdy_n  = (state_n == IDLE);
  end

  // State and output registers; reset drops tran_en without waiting for a clock.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= IDLE;
      target      <= 16'd0;
      frames_done <= 16'd0;
      op_cfg      <= 5'd0;
      stop_lat    <= 1'b0;
      err         <= 2'b00;
      done        <= 1'b0;
      tran_en     <= 1'b0;
      busy        <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state       <= state_n;
      target      <= target_n;
      frames_done <= frames_n;
      op_cfg      <= op_cfg_n;
      stop_lat    <= stop_n;
      err         <= err_n;
      done        <= done_n;
      tran_en     <= tran_en_n;
      busy        <= busy_n;
      rdy_q       <= rdy_n;
    end
  end

endmodule

// File: tb/tb_i2s_seq_ctrl.sv
// tb/tb_i2s_seq_ctrl.sv - self-checking bench for i2s_seq_ctrl
module tb_i2s_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        stop_req = 1'b0, abort = 1'b0, frame_start = 1'b0, frame_end = 1'b0;
  logic        tx_empty = 1'b0, rx_full = 1'b0, err_clr = 1'b0;
  logic [4:0]  op_cfg;
  logic        tran_en, busy, done;
  logic [15:0] frames_done;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  i2s_seq_ctrl_if cif ();

  i2s_seq_ctrl dut (
    .clk         (clk),
    .rst_        (rst_),
    .cmd         (cif.slave),
    .stop_req    (stop_req),
    .abort       (abort),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .tx_empty    (tx_empty),
    .rx_full     (rx_full),
    .err_clr     (err_clr),
    .op_cfg      (op_cfg),
    .tran_en     (tran_en),
    .busy        (busy),
    .done        (done),
    .frames_done (frames_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 armed, 2 running, 3 last frame.
  int         m_ph, m_tgt, m_cnt;
  logic [4:0] m_cfg;
  logic [1:0] m_err;
  bit         m_stop, m_done, m_tran;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_ph = 0; m_tgt = 0; m_cnt = 0; m_cfg = '0; m_err = '0;
      m_stop = 0; m_done = 0; m_tran = 0;
    end else begin
      logic [1:0] se;
      se = 2'b00;
      if (m_ph == 2 && frame_end) begin
        if (m_cfg[4:3] == 2'd0 && tx_empty) se[0] = 1'b1;
        if (m_cfg[4:3] == 2'd1 && rx_full)  se[1] = 1'b1;
      end
      if (err_clr) m_err = 2'b00;
      m_err = m_err | se;
      m_done = 0;
      case (m_ph)
        0: if (cif.cmd_valid && !abort) begin
             m_cfg = cif.cmd_cfg; m_tgt = int'(cif.cmd_frames); m_cnt = 0; m_ph = 1;
           end
        1: if (abort) m_ph = 0;
           else begin
             if (stop_req) m_stop = 1;
             if (frame_start) m_ph = (m_tgt == 1) ? 3 : 2;
           end
        2: if (abort) m_ph = 0;
           else begin
             if (stop_req) m_stop = 1;
             if (frame_end) begin
               m_cnt = (m_cnt + 1) % 65536;
               if (m_tgt != 0 && m_tgt - m_cnt == 1) m_ph = 3;
             end
             if (m_stop) m_ph = 3;
           end
        default: if (abort) m_ph = 0;
           else if (frame_end) begin
             m_cnt = (m_cnt + 1) % 65536; m_done = 1; m_ph = 0;
           end
      endcase
      if (m_ph == 0) m_stop = 0;
      if (m_ph == 2) m_tran = 1;
      else if (m_ph == 1)
        m_tran = (m_cfg[4:3] == 2'd0) ? !tx_empty : (m_cfg[4:3] == 2'd1) ? !rx_full : 1'b1;
      else m_tran = 0;
    end
  end

  // Every-cycle comparison against the model, half a period away from the active edge.
  always @(negedge clk) begin
    if (rst_) begin
      chk("cmd_ready", cif.cmd_ready, (m_ph == 0) && !abort);
      chk("tran_en", tran_en, m_tran);
      chk("busy", busy, m_ph != 0);
      chk("done", done, m_done);
      chk("frames_done", frames_done, m_cnt[15:0]);
      chk("err", err, m_err);
      chk("op_cfg", op_cfg, m_cfg);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic [15:0] f, input logic [4:0] c);
    cif.cmd_valid = 1'b1; cif.cmd_frames = f; cif.cmd_cfg = c;
    cyc(1);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1; cyc(1); frame_end = 1'b0;
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_frames = '0; cif.cmd_cfg = '0;
    cyc(3);
    chk("rst_tran_en", tran_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_cfg", op_cfg, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_err", err, 0);
    rst_ = 1'b1;
    cyc(1);
    chk("rel_cmd_ready", cif.cmd_ready, 1);

    // Three frames, master transmit.
    send_cmd(16'd3, 5'b00111);
    chk("s1_arm_tran", tran_en, 1);
    cyc(2);
    pulse_fs();
    cyc(2);
    pulse_fe();
    chk("s1_run_tran", tran_en, 1);
    cyc(2);
    pulse_fe();
    chk("s1_last_tran", tran_en, 0);
    chk("s1_fd2", frames_done, 2);
    cyc(2);
    pulse_fe();
    chk("s1_done", done, 1);
    chk("s1_fd3", frames_done, 3);
    chk("s1_busy", busy, 0);
    cyc(1);
    chk("s1_done_once", done, 0);

    // Single frame goes straight to LAST.
    send_cmd(16'd1, 5'b01000);
    pulse_fs();
    chk("s2_tran", tran_en, 0);
    chk("s2_busy", busy, 1);
    cyc(1);
    pulse_fe();
    chk("s2_done", done, 1);
    chk("s2_fd", frames_done, 1);

    // Continuous slave receive, stopped after five frames.
    cyc(1);
    send_cmd(16'd0, 5'b11100);
    pulse_fs();
    repeat (5) begin pulse_fe(); cyc(1); end
    chk("s3_fd5", frames_done, 5);
    stop_req = 1'b1; cyc(1); stop_req = 1'b0;
    chk("s3_last_tran", tran_en, 0);
    cyc(1);
    pulse_fe();
    chk("s3_done", done, 1);
    chk("s3_fd6", frames_done, 6);
    chk("s3_err", err, 0);

    // Transmit underrun is sticky; clear loses to a coincident set.
    cyc(1);
    send_cmd(16'd0, 5'b00000);
    pulse_fs();
    pulse_fe();
    tx_empty = 1'b1;
    pulse_fe();
    chk("s4_err_set", err, 2'b01);
    tx_empty = 1'b0;
    cyc(2);
    chk("s4_err_sticky", err, 2'b01);
    tx_empty = 1'b1; frame_end = 1'b1; err_clr = 1'b1;
    cyc(1);
    frame_end = 1'b0; err_clr = 1'b0; tx_empty = 1'b0;
    chk("s4_clr_lose", err, 2'b01);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("s4_clr", err, 2'b00);
    abort = 1'b1; cyc(1); abort = 1'b0;

    // Abort on a frame boundary, then an immediate new command.
    send_cmd(16'd4, 5'b10000);
    pulse_fs();
    pulse_fe();
    cyc(1);
    frame_end = 1'b1; abort = 1'b1;
    cyc(1);
    frame_end = 1'b0; abort = 1'b0;
    chk("s5_busy", busy, 0);
    chk("s5_fd", frames_done, 1);
    chk("s5_done", done, 0);
    chk("s5_tran", tran_en, 0);
    tx_empty = 1'b1;
    send_cmd(16'd2, 5'b00101);
    chk("s5_accept", busy, 1);
    chk("s5_cfg", op_cfg, 5'b00101);
    chk("s5_fd0", frames_done, 0);
    chk("s5_arm_wait", tran_en, 0);
    tx_empty = 1'b0;
    cyc(1);
    chk("s5_arm_go", tran_en, 1);
    pulse_fe();
    chk("s5_arm_nocount", frames_done, 0);
    abort = 1'b1; cyc(1); abort = 1'b0;

    // Stop latched in ARM ends a finite transfer early; stop in IDLE is ignored.
    send_cmd(16'd10, 5'b11000);
    stop_req = 1'b1; cyc(1); stop_req = 1'b0;
    pulse_fs();
    cyc(1);
    chk("s6_early_last", tran_en, 0);
    pulse_fe();
    chk("s6_done", done, 1);
    chk("s6_fd", frames_done, 1);
    stop_req = 1'b1; cyc(1); stop_req = 1'b0;
    send_cmd(16'd3, 5'b11000);
    pulse_fs();
    cyc(2);
    chk("s6_idle_stop_ignored", tran_en, 1);

    // Reset while running.
    abort = 1'b1; cyc(1); abort = 1'b0;
    send_cmd(16'd0, 5'b11000);
    pulse_fs();
    cyc(2);
    #1 rst_ = 1'b0;
    #1;
    chk("s7_tran", tran_en, 0);
    chk("s7_busy", busy, 0);
    chk("s7_cfg", op_cfg, 0);
    chk("s7_fd", frames_done, 0);
    chk("s7_done", done, 0);
    cyc(2);
    rst_ = 1'b1;
    cyc(1);
    chk("s7_ready", cif.cmd_ready, 1);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
